// File: rtl/alu_io_pkg.sv
// alu_io_pkg -- shared types for the ALU front-end.
//   state_t      : operand-entry sequence states (S_A, S_B, S_OP, S_RUN)
//   OP_*         : ALU operation select encodings
//   state_onehot : state to one-hot LED pattern (bit0 S_A .. bit3 S_RUN)
package alu_io_pkg;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RUN = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  function automatic logic [3:0] state_onehot(input state_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/button_edge.sv
// button_edge -- pushbutton conditioner: two-flop synchroniser followed by a
// one-flop rising-edge detector.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   btn     : raw asynchronous button
//   pulse   : one-cycle pulse per press (high the cycle after the second
//             synchroniser flop first sees the button high)
module button_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic pulse
);

  localparam int STAGES = 2;

  logic [1:0]      sync;
  logic            prev;
  // vld_pipe[i] marks that stage i holds a real post-reset sample; the edge
  // detector only fires once prev is real, so a button held through reset
  // does not produce a spurious press on release.
  logic [STAGES:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync     <= '0;
      prev     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      sync     <= {sync[0], btn};
      prev     <= sync[1];
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  assign pulse = sync[1] & ~prev & vld_pipe[STAGES];

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader -- collects A, B and OpCode from switches via Enter/Back
// buttons and presents a complete operation to the ALU.
//   clk, reset_n : clock, synchronous active-low reset
//   DataIn       : switch value captured on an Enter press
//   Enter, Back  : raw pushbuttons (advance / step back one state)
//   A, B         : registered operands
//   OpCode       : registered operation select (DataIn[1:0])
//   Valid        : high while in S_RUN (lags the state by one cycle)
//   StateLed     : registered one-hot copy of the state
module alu_operand_loader
  import alu_io_pkg::*;
#(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [M-1:0] DataIn,
  input  logic         Enter,
  input  logic         Back,
  output logic [M-1:0] A,
  output logic [M-1:0] B,
  output logic [1:0]   OpCode,
  output logic         Valid,
  output logic [3:0]   StateLed
);

  localparam int NUM_BTN   = 2;
  localparam int BTN_ENTER = 0;
  localparam int BTN_BACK  = 1;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_pulse;

  assign btn_raw = {Back, Enter};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      button_edge u_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_raw[gi]),
        .pulse   (btn_pulse[gi])
      );
    end
  endgenerate

  // Back wins a simultaneous press; the Enter pulse is dropped.
  logic back_go, enter_go;
  assign back_go  = btn_pulse[BTN_BACK];
  assign enter_go = btn_pulse[BTN_ENTER] & ~btn_pulse[BTN_BACK];

  state_t state, state_nxt;

  always_comb begin
    state_nxt = state;
    if (back_go) begin
      case (state)
        S_B:     state_nxt = S_A;
        S_OP:    state_nxt = S_B;
        S_RUN:   state_nxt = S_OP;
        default: state_nxt = S_A;
      endcase
    end else if (enter_go) begin
      case (state)
        S_A:     state_nxt = S_B;
        S_B:     state_nxt = S_OP;
        S_OP:    state_nxt = S_RUN;
        default: state_nxt = S_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_A;
      A        <= '0;
      B        <= '0;
      OpCode   <= OP_ADD;
      Valid    <= 1'b0;
      StateLed <= state_onehot(S_A);
    end else begin
      state    <= state_nxt;
      StateLed <= state_onehot(state_nxt);
      // Registered from the current state, so it trails S_RUN entry/exit by a cycle.
      Valid    <= (state == S_RUN);
      if (enter_go) begin
        case (state)
          S_A:     A      <= DataIn;
          S_B:     B      <= DataIn;
          S_OP:    OpCode <= DataIn[1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader -- scoreboard bench: the driver pushes timed
// expectations from a transaction-level model, a negedge monitor compares.
module tb_alu_operand_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] DataIn;
  logic       Enter, Back;
  logic [3:0] A, B;
  logic [1:0] OpCode;
  logic       Valid;
  logic [3:0] StateLed;

  alu_operand_loader #(.M(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .DataIn   (DataIn),
    .Enter    (Enter),
    .Back     (Back),
    .A        (A),
    .B        (B),
    .OpCode   (OpCode),
    .Valid    (Valid),
    .StateLed (StateLed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expectation: {A, B, OpCode, Valid, StateLed} due at negedge of cycle 'due'
  typedef struct {
    int          due;
    logic [14:0] val;
  } exp_t;

  exp_t  sq[$];
  string nq[$];
  int    checks = 0;
  int    passed = 0;

  // reference model: operand registers and state as 0..3 (A, B, OP, RUN)
  logic [3:0] ma, mb;
  logic [1:0] mo;
  int         ms;

  task automatic push(input int due, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op, input logic v, input int st,
                      input string nm);
    exp_t e;
    logic [3:0] led;
    led   = 4'd1 << st;
    e.due = due;
    e.val = {a, b, op, v, led};
    sq.push_back(e);
    nq.push_back(nm);
  endtask

  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].due <= cyc) begin
      exp_t  e;
      string nm;
      logic [14:0] got;
      e   = sq.pop_front();
      nm  = nq.pop_front();
      got = {A, B, OpCode, Valid, StateLed};
      checks++;
      if (e.due < cyc)
        $display("FAIL %s: check missed (due cycle %0d, now %0d)", nm, e.due, cyc);
      else if (got !== e.val)
        $display("FAIL %s @cyc %0d: got A=%b B=%b Op=%b V=%b Led=%b, want A=%b B=%b Op=%b V=%b Led=%b",
                 nm, cyc, got[14:11], got[10:7], got[6:5], got[4], got[3:0],
                 e.val[14:11], e.val[10:7], e.val[6:5], e.val[4], e.val[3:0]);
      else
        passed++;
    end
  end

  // One press: raw buttons high for 'hold' cycles. The model predicts the
  // old outputs one edge before the load, the new registers at the load edge
  // (Valid still old), and everything new one edge later.
  task automatic press(input bit en, input bit bk, input logic [3:0] d,
                       input int hold, input string nm);
    int k, os;
    logic [3:0] oa, ob;
    logic [1:0] oo;
    logic ov;
    @(posedge clk); #1;
    k = cyc; DataIn = d; Enter = en; Back = bk;
    oa = ma; ob = mb; oo = mo; os = ms; ov = (os == 3);
    if (bk) begin
      if (ms > 0) ms = ms - 1;
    end else if (en) begin
      case (ms)
        0: ma = d;
        1: mb = d;
        2: mo = d[1:0];
        default: ;
      endcase
      ms = (ms + 1) % 4;
    end
    push(k + 2, oa, ob, oo, ov, os, {nm, "/pre"});
    push(k + 3, ma, mb, mo, ov, ms, {nm, "/load"});
    push(k + 4, ma, mb, mo, (ms == 3), ms, {nm, "/valid"});
    if (hold > 4) push(k + hold, ma, mb, mo, (ms == 3), ms, {nm, "/held"});
    for (int i = 1; i <= hold + 4; i++) begin
      @(posedge clk); #1;
      if (i == hold) begin Enter = 1'b0; Back = 1'b0; end
      if (i >= 3) DataIn = 4'($urandom);
    end
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      DataIn = 4'($urandom);
    end
    push(cyc, ma, mb, mo, (ms == 3), ms, nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_n = 1'b0; DataIn = 4'b0000; Enter = 1'b0; Back = 1'b0;
    ma = '0; mb = '0; mo = '0; ms = 0;
    repeat (2) @(posedge clk);
    #1;
    push(cyc, 4'h0, 4'h0, 2'b00, 1'b0, 0, "reset");
    reset_n = 1'b1;

    // full sequence to S_RUN
    press(1, 0, 4'b1111, 2, "enterA");
    press(1, 0, 4'b0001, 3, "enterB");
    press(1, 0, 4'b0000, 1, "enterOp");

    // switches wiggle with no press, then leave S_RUN
    idle(6, "run_idle");
    press(1, 0, 4'b1010, 2, "run_exit");

    // long hold in S_A: exactly one load
    press(1, 0, 4'b0101, 50, "long_hold");

    // to S_OP, back to S_B, reload B
    press(1, 0, 4'b1100, 2, "toOp");
    press(0, 1, 4'b1001, 2, "backOp");
    press(1, 0, 4'b0000, 2, "reloadB");

    // simultaneous Enter+Back in S_B: Back wins
    press(0, 1, 4'b0111, 2, "backB");
    press(1, 1, 4'b1110, 2, "both");
    press(0, 1, 4'b0011, 2, "backInA");

    // go to S_RUN, then reset while Enter pulse coincides with reset edge
    press(1, 0, 4'b0110, 2, "runA");
    press(1, 0, 4'b1011, 2, "runB");
    press(1, 0, 4'b0111, 2, "runOp");
    @(posedge clk); #1;
    k = cyc; Enter = 1'b1; DataIn = 4'b1101;
    push(k + 2, ma, mb, mo, 1'b1, 3, "rst_pre");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    ma = '0; mb = '0; mo = '0; ms = 0;
    push(k + 3, 4'h0, 4'h0, 2'b00, 1'b0, 0, "rst_held");
    push(k + 14, 4'h0, 4'h0, 2'b00, 1'b0, 0, "rst_no_load");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    Enter = 1'b0;
    repeat (4) @(posedge clk);
    press(1, 0, 4'b1001, 2, "after_rst");

    // randomized presses
    for (int n = 0; n < 40; n++) begin
      int r, h;
      r = $urandom_range(0, 3);
      h = ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(1, 6);
      press(r != 2, r >= 2, 4'($urandom), h, $sformatf("rnd%0d", n));
    end

    repeat (3) @(posedge clk);
    #1;
    if (sq.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations never checked, want 0", sq.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
